picosoc_bus_fabric: RTL and testbench

PICOSOC_BUS_FABRIC -- requirements
Module: picosoc_bus_fabric

---
 rtl/picosoc_bus_pkg.sv | 21 ++
 rtl/picosoc_bus_fabric_if.sv | 44 ++++
 rtl/picosoc_addr_decode.sv | 29 ++
 rtl/picosoc_bus_fabric.sv | 153 +++++++++++++++
 tb/tb_picosoc_bus_fabric.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoSoC bus fabric.
// FSM encoding, error cause codes and the default error read data.
package picosoc_bus_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StActive = 2'b01,
        StResp   = 2'b10,
        StErr    = 2'b11
    } state_e;

    localparam logic [1:0]  ERR_CAUSE_DECODE  = 2'b01;
    localparam logic [1:0]  ERR_CAUSE_TIMEOUT = 2'b10;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Index width that stays legal for a single slave.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/picosoc_bus_fabric_if.sv
// CPU-side and slave-side bus signals of the fabric plus the sticky error status.
// The fabric uses the slave modport; the CPU/slave environment uses the master modport.
interface picosoc_bus_fabric_if #(
    parameter int unsigned N_SLAVES = 4
);
    logic                    mem_valid;
    logic                    mem_instr;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic [3:0]              mem_wstrb;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;

    logic [N_SLAVES-1:0]     s_valid;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [N_SLAVES-1:0]     s_ready;
    logic [N_SLAVES*32-1:0]  s_rdata;

    logic                    err_clr;
    logic                    err_flag;
    logic [1:0]              err_cause;
    logic [31:0]             err_addr;

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata,
        input  err_clr,
        output err_flag, err_cause, err_addr
    );

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata,
        output err_clr,
        input  err_flag, err_cause, err_addr
    );

endinterface

// File: rtl/picosoc_addr_decode.sv
// Combinational address decoder: mask/compare per slave, lowest matching index wins.
module picosoc_addr_decode
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned            N_SLAVES = 4,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE = {32'h0300_0000, 32'h0200_0000,
                                                  32'h0010_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK = {32'hFF00_0000, 32'hFF00_0000,
                                                  32'hFFF0_0000, 32'hFFFF_F000},
    localparam int unsigned           IdxW     = idx_width(N_SLAVES)
) (
    input  logic [31:0]     addr,
    output logic            hit,
    output logic [IdxW-1:0] idx
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit = 1'b1;
                idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// Single-outstanding PicoSoC bus fabric: decodes a CPU request to one of N slaves,
// with slave-wait timeout, error responses and a sticky first-error record.
module picosoc_bus_fabric
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned            N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE       = {32'h0300_0000, 32'h0200_0000,
                                                        32'h0010_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK       = {32'hFF00_0000, 32'hFF00_0000,
                                                        32'hFFF0_0000, 32'hFFFF_F000},
    parameter int unsigned            TIMEOUT_CYCLES = 255,
    parameter logic [31:0]            ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input logic                  clk,
    input logic                  resetn,
    picosoc_bus_fabric_if.slave  bus
);

    localparam int unsigned IdxW = idx_width(N_SLAVES);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, wdata_q;
    logic [3:0]          wstrb_q;
    logic [IdxW-1:0]     sel_q;
    logic [31:0]         rdata_q;
    logic [31:0]         cnt_q;
    logic                err_flag_q;
    logic [1:0]          err_cause_q;
    logic [31:0]         err_addr_q;

    logic                dec_hit;
    logic [IdxW-1:0]     dec_idx;
    logic                sel_ready;
    logic [31:0]         sel_rdata;
    logic                timeout;
    logic                err_event;
    logic [1:0]          err_cause_new;
    logic [31:0]         err_addr_new;

    logic [N_SLAVES-1:0] slv_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic                unused_instr;

    picosoc_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (bus.mem_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign unused_instr = bus.mem_instr;
    assign sel_ready    = bus.s_ready[sel_q];
    assign sel_rdata    = bus.s_rdata[32*sel_q +: 32];
    assign timeout      = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A ready sampled on the timeout edge takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.mem_valid) state_d = dec_hit ? StActive : StErr;
            StActive: begin
                if (sel_ready)    state_d = StResp;
                else if (timeout) state_d = StErr;
            end
            StResp:   state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        slv_valid = '0;
        rsp_ready = 1'b0;
        rsp_rdata = '0;
        unique case (state_q)
            StActive: slv_valid[sel_q] = 1'b1;
            StResp: begin
                rsp_ready = 1'b1;
                rsp_rdata = rdata_q;
            end
            StErr: begin
                rsp_ready = 1'b1;
                rsp_rdata = ERR_RDATA;
            end
            default: ;
        endcase
    end

    assign err_event     = (state_d == StErr) && (state_q != StErr);
    assign err_cause_new = (state_q == StIdle) ? ERR_CAUSE_DECODE : ERR_CAUSE_TIMEOUT;
    assign err_addr_new  = (state_q == StIdle) ? bus.mem_addr : addr_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            sel_q       <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            err_cause_q <= '0;
            err_addr_q  <= '0;
        end else begin
            if (state_q == StIdle && bus.mem_valid) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
                sel_q   <= dec_idx;
            end
            // Held at zero outside ACTIVE so every entry starts a fresh count.
            if (state_q == StActive) begin
                cnt_q <= cnt_q + 32'd1;
                if (sel_ready) rdata_q <= sel_rdata;
            end else begin
                cnt_q <= '0;
            end
            if (bus.err_clr) begin
                err_flag_q  <= 1'b0;
                err_cause_q <= '0;
                err_addr_q  <= '0;
            end
            if (err_event && (!err_flag_q || bus.err_clr)) begin
                err_flag_q  <= 1'b1;
                err_cause_q <= err_cause_new;
                err_addr_q  <= err_addr_new;
            end
        end
    end

    assign bus.s_valid   = slv_valid;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_wstrb   = wstrb_q;
    assign bus.mem_ready = rsp_ready;
    assign bus.mem_rdata = rsp_rdata;
    assign bus.err_flag  = err_flag_q;
    assign bus.err_cause = err_cause_q;
    assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Directed bench for picosoc_bus_fabric: reads, writes, decode miss, timeout,
// sticky error handling, overlap priority and mid-transaction reset.
module tb_picosoc_bus_fabric;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    picosoc_bus_fabric_if #(.N_SLAVES(4)) bus ();

    // Slaves 0 and 2 overlap at 0x0000_0000; slave 0 must win.
    picosoc_bus_fabric #(
        .N_SLAVES       (4),
        .SLV_BASE       ({32'h0300_0000, 32'h0000_0000, 32'h0010_0000, 32'h0000_0000}),
        .SLV_MASK       ({32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for mem_ready; lat counts the request cycle as 1.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int lat, output logic got_ready,
                           output logic [31:0] rdata, output logic [3:0] sv_seen,
                           output int sv_cycles, output logic after_ready,
                           output logic [31:0] after_rdata);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat       = 1;
        sv_seen   = '0;
        sv_cycles = 0;
        do begin
            tick();
            lat++;
            sv_seen |= bus.s_valid;
            if (|bus.s_valid) sv_cycles++;
        end while (!bus.mem_ready && lat < 40);
        got_ready     = bus.mem_ready;
        rdata         = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        tick();
        after_ready = bus.mem_ready;
        after_rdata = bus.mem_rdata;
    endtask

    int          lat, svc;
    logic        rdy, aft_rdy;
    logic [31:0] rd, aft_rd;
    logic [3:0]  svs;

    initial begin
        resetn        = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.s_ready   = '0;
        bus.s_rdata   = {32'h3333_3333, 32'hCAFE_0002, 32'h1234_5678, 32'hA5A5_0000};
        bus.err_clr   = 1'b0;
        tick();
        tick();
        check("rst_s_valid", 32'(bus.s_valid), 32'h0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
        check("rst_mem_rdata", bus.mem_rdata, 32'h0);
        check("rst_err_flag", 32'(bus.err_flag), 32'h0);
        check("rst_err_cause", 32'(bus.err_cause), 32'h0);
        check("rst_err_addr", bus.err_addr, 32'h0);
        resetn = 1'b1;
        tick();

        // Zero-wait read from slave 1.
        bus.s_ready = 4'b0010;
        run_req(32'h0010_0004, 32'h0, 4'h0, lat, rdy, rd, svs, svc, aft_rdy, aft_rd);
        check("rd_s_valid", 32'(svs), 32'h2);
        check("rd_ready", 32'(rdy), 32'h1);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_rdata", rd, 32'h1234_5678);
        check("rd_ready_one_cycle", 32'(aft_rdy), 32'h0);
        check("rd_rdata_idle_zero", aft_rd, 32'h0);
        check("rd_s_addr", bus.s_addr, 32'h0010_0004);

        // Write to slave 1 carries data and strobes.
        run_req(32'h0010_0008, 32'hAABB_CCDD, 4'b0101, lat, rdy, rd, svs, svc, aft_rdy, aft_rd);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_s_wdata", bus.s_wdata, 32'hAABB_CCDD);
        check("wr_s_wstrb", 32'(bus.s_wstrb), 32'h5);
        check("wr_err_flag", 32'(bus.err_flag), 32'h0);

        // Decode miss on a write.
        run_req(32'h0400_0000, 32'h1111_2222, 4'hF, lat, rdy, rd, svs, svc, aft_rdy, aft_rd);
        check("miss_s_valid", 32'(svs), 32'h0);
        check("miss_latency", 32'(lat), 32'd2);
        check("miss_rdata", rd, 32'hDEAD_BEEF);
        check("miss_ready_one_cycle", 32'(aft_rdy), 32'h0);
        check("miss_err_flag", 32'(bus.err_flag), 32'h1);
        check("miss_err_cause", 32'(bus.err_cause), 32'h1);
        check("miss_err_addr", bus.err_addr, 32'h0400_0000);

        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr_err_flag", 32'(bus.err_flag), 32'h0);
        check("clr_err_addr", bus.err_addr, 32'h0);

        // Slave 3 never ready: times out after 8 cycles of s_valid.
        run_req(32'h0300_0010, 32'h0, 4'h0, lat, rdy, rd, svs, svc, aft_rdy, aft_rd);
        check("to_s_valid", 32'(svs), 32'h8);
        check("to_valid_cycles", 32'(svc), 32'd8);
        check("to_latency", 32'(lat), 32'd10);
        check("to_rdata", rd, 32'hDEAD_BEEF);
        check("to_err_cause", 32'(bus.err_cause), 32'h2);
        check("to_err_addr", bus.err_addr, 32'h0300_0010);

        // A later miss keeps the first error.
        run_req(32'h0500_0000, 32'h0, 4'h0, lat, rdy, rd, svs, svc, aft_rdy, aft_rd);
        check("sticky_rdata", rd, 32'hDEAD_BEEF);
        check("sticky_err_addr", bus.err_addr, 32'h0300_0010);
        check("sticky_err_cause", 32'(bus.err_cause), 32'h2);

        // err_clr on the same edge as a new miss records the new error.
        bus.err_clr   = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0600_0000;
        tick();
        bus.err_clr   = 1'b0;
        bus.mem_valid = 1'b0;
        check("clrnew_ready", 32'(bus.mem_ready), 32'h1);
        check("clrnew_err_flag", 32'(bus.err_flag), 32'h1);
        check("clrnew_err_cause", 32'(bus.err_cause), 32'h1);
        check("clrnew_err_addr", bus.err_addr, 32'h0600_0000);
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr2_err_cause", 32'(bus.err_cause), 32'h0);
        check("clr2_err_addr", bus.err_addr, 32'h0);

        // Ready arriving on the timeout edge wins.
        bus.s_ready   = 4'b0000;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0300_0020;
        for (int i = 0; i < 8; i++) tick();
        check("tie_still_waiting", 32'(bus.s_valid), 32'h8);
        bus.s_ready = 4'b1000;
        tick();
        check("tie_ready", 32'(bus.mem_ready), 32'h1);
        check("tie_rdata", bus.mem_rdata, 32'h3333_3333);
        check("tie_err_flag", 32'(bus.err_flag), 32'h0);
        bus.mem_valid = 1'b0;
        bus.s_ready   = 4'b0000;
        tick();

        // Overlap: slave 0 wins; a ready from slave 2 is ignored.
        bus.s_ready   = 4'b0100;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0010;
        tick();
        check("ovl_s_valid", 32'(bus.s_valid), 32'h1);
        tick();
        tick();
        check("ovl_glitch_ignored", 32'(bus.mem_ready), 32'h0);
        check("ovl_s_valid_held", 32'(bus.s_valid), 32'h1);
        bus.s_ready = 4'b0001;
        tick();
        check("ovl_ready", 32'(bus.mem_ready), 32'h1);
        check("ovl_rdata", bus.mem_rdata, 32'hA5A5_0000);
        bus.mem_valid = 1'b0;
        bus.s_ready   = 4'b0000;
        tick();

        // Reset while waiting on slave 3 aborts without a response.
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0300_0000;
        tick();
        check("rstmid_active", 32'(bus.s_valid), 32'h8);
        resetn = 1'b0;
        tick();
        check("rstmid_s_valid", 32'(bus.s_valid), 32'h0);
        check("rstmid_ready", 32'(bus.mem_ready), 32'h0);
        bus.mem_valid = 1'b0;
        tick();
        check("rstmid_ready_hold", 32'(bus.mem_ready), 32'h0);
        resetn = 1'b1;
        tick();
        bus.s_ready = 4'b0010;
        run_req(32'h0010_0004, 32'h0, 4'h0, lat, rdy, rd, svs, svc, aft_rdy, aft_rd);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rdata", rd, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
